// File: rtl/pwm_pkg.sv
// Shared constants and types for the LED PWM fade scheduler.
package pwm_pkg;

    localparam int PWM_PERIOD = 255;
    localparam int DUTY_W     = 8;
    localparam int RATE_W     = 4;
    localparam int FRAME_HZ   = 60;

    typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/pwm_fade_channel.sv
// One PWM channel: target/rate registers, saturating per-frame fade step,
// period-boundary commit of the working level and the registered compare.
module pwm_fade_channel #(
    parameter int DUTY_W = pwm_pkg::DUTY_W,
    parameter int RATE_W = pwm_pkg::RATE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pwmTick,
    input  logic              i_wrap,
    input  logic [DUTY_W-1:0] i_phaseNext,
    input  logic              i_frameTick,
    input  logic              i_wrEn,
    input  logic [DUTY_W-1:0] i_wrTarget,
    input  logic [RATE_W-1:0] i_wrRate,
    output logic              o_pwm,
    output logic              o_active
);

    localparam int EXT_W = DUTY_W + 1;

    logic [DUTY_W-1:0] r_cur;
    logic [DUTY_W-1:0] r_tgt;
    logic [RATE_W-1:0] r_rate;
    logic [DUTY_W-1:0] r_applied;

    logic [EXT_W-1:0]  w_rateExt;
    logic [EXT_W-1:0]  w_up;
    logic [EXT_W-1:0]  w_down;
    logic [DUTY_W-1:0] w_stepped;
    logic [DUTY_W-1:0] w_appliedNext;

    // One extra bit catches both overflow going up and borrow going down.
    always_comb begin
        w_rateExt = EXT_W'(r_rate);
        w_up      = {1'b0, r_cur} + w_rateExt;
        w_down    = {1'b0, r_cur} - w_rateExt;
        w_stepped = r_cur;
        if (r_cur < r_tgt) begin
            w_stepped = (w_up > {1'b0, r_tgt}) ? r_tgt : w_up[DUTY_W-1:0];
        end else if (r_cur > r_tgt) begin
            w_stepped = (w_down[DUTY_W] || (w_down[DUTY_W-1:0] < r_tgt))
                        ? r_tgt : w_down[DUTY_W-1:0];
        end
    end

    // The compare at phase 0 already sees the freshly committed level.
    assign w_appliedNext = i_wrap ? r_cur : r_applied;
    assign o_active      = (r_cur != r_tgt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur     <= '0;
            r_tgt     <= '0;
            r_rate    <= '0;
            r_applied <= '0;
            o_pwm     <= 1'b0;
        end else begin
            if (i_wrap) begin
                r_applied <= r_cur;
            end
            if (i_pwmTick) begin
                o_pwm <= (i_phaseNext < w_appliedNext);
            end
            if (i_wrEn) begin
                r_tgt  <= i_wrTarget;
                r_rate <= i_wrRate;
                if (i_wrRate == '0) begin
                    r_cur <= i_wrTarget;
                end
            end else if (i_frameTick) begin
                r_cur <= w_stepped;
            end
        end
    end

endmodule

// File: rtl/pwm_fade_scheduler.sv
// LED PWM sequencer: shared phase counter, write handshake/decode,
// NUM_CH fading channels and the registered busy reduction.
module pwm_fade_scheduler #(
    parameter int NUM_CH = 4,
    parameter int DUTY_W = pwm_pkg::DUTY_W,
    parameter int RATE_W = pwm_pkg::RATE_W,
    parameter int PERIOD = pwm_pkg::PWM_PERIOD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pwm_tick,
    input  logic                    frame_tick,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [$clog2(NUM_CH):0] wr_ch,
    input  logic [DUTY_W-1:0]       wr_target,
    input  logic [RATE_W-1:0]       wr_rate,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start,
    output logic                    busy
);

    // The channel index carries one spare bit so out-of-range writes are
    // representable and can be swallowed without aliasing onto a channel.
    localparam int CH_W = $clog2(NUM_CH) + 1;

    logic [DUTY_W-1:0] r_phase;
    logic              r_readyEn;
    logic [DUTY_W-1:0] w_phaseNext;
    logic              w_wrap;
    logic              w_xfer;
    logic [NUM_CH-1:0] w_active;

    assign w_wrap      = pwm_tick && (r_phase == DUTY_W'(PERIOD - 1));
    assign w_phaseNext = !pwm_tick ? r_phase :
                         w_wrap    ? '0      : r_phase + 1'b1;

    // Writes are refused on frame_tick cycles so a write never races a fade step.
    assign wr_ready = r_readyEn && !frame_tick;
    assign w_xfer   = wr_valid && wr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase      <= '0;
            r_readyEn    <= 1'b0;
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_phase      <= w_phaseNext;
            r_readyEn    <= 1'b1;
            period_start <= w_wrap;
            busy         <= |w_active;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_fade_channel #(
            .DUTY_W(DUTY_W),
            .RATE_W(RATE_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .i_pwmTick  (pwm_tick),
            .i_wrap     (w_wrap),
            .i_phaseNext(w_phaseNext),
            .i_frameTick(frame_tick),
            .i_wrEn     (w_xfer && (wr_ch == CH_W'(i))),
            .i_wrTarget (wr_target),
            .i_wrRate   (wr_rate),
            .o_pwm      (pwm_out[i]),
            .o_active   (w_active[i])
        );
    end

endmodule
